// File: rtl/ft245_sync_fifo_device.sv
// Device (chip) end of an FT232H-style 245 synchronous FIFO bus with host-side
// valid/ready byte streams and an optional forced TXE# stall after each TX burst.
module ft245_sync_fifo_device #(
   parameter int DEPTH_LOG2 = 4,
   parameter int TX_BURST   = 0,
   parameter int TX_GAP     = 3
) (
   input  logic                  ft_clk,
   input  logic                  rst,
   output logic                  ft_rxf_n,
   output logic                  ft_txe_n,
   input  logic                  ft_oe_n,
   input  logic                  ft_rd_n,
   input  logic                  ft_wr_n,
   inout  wire  [7:0]            ft_data,
   input  logic [7:0]            host_rx_data,
   input  logic                  host_rx_valid,
   output logic                  host_rx_ready,
   output logic [7:0]            host_tx_data,
   output logic                  host_tx_valid,
   input  logic                  host_tx_ready,
   output logic [DEPTH_LOG2:0]   rx_count,
   output logic [DEPTH_LOG2:0]   tx_count,
   output logic                  proto_err
);

   localparam int                  DEPTH      = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT   = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] ZERO_CNT   = (DEPTH_LOG2 + 1)'(32'd0);
   localparam logic [DEPTH_LOG2:0] ONE_CNT    = (DEPTH_LOG2 + 1)'(32'd1);
   localparam logic [DEPTH_LOG2-1:0] ONE_PTR  = (DEPTH_LOG2)'(32'd1);
   localparam logic                STALL_EN   = (TX_BURST != 0);
   localparam logic [15:0]         BURST_LAST = 16'(TX_BURST - 1);
   localparam logic [15:0]         GAP_LAST   = 16'(TX_GAP - 1);

   typedef enum logic [0:0] {
      ST_OPEN = 1'b0,
      ST_GAP  = 1'b1
   } stall_state_t;

   logic [7:0]            rx_mem_r [DEPTH];
   logic [DEPTH_LOG2-1:0] rx_wr_ptr_r;
   logic [DEPTH_LOG2-1:0] rx_rd_ptr_r;
   logic [DEPTH_LOG2:0]   rx_count_next_s;
   logic                  rx_push_s;
   logic                  rx_pop_s;
   logic [7:0]            rx_head_s;

   logic [7:0]            tx_mem_r [DEPTH];
   logic [DEPTH_LOG2-1:0] tx_wr_ptr_r;
   logic [DEPTH_LOG2-1:0] tx_rd_ptr_r;
   logic [DEPTH_LOG2:0]   tx_count_next_s;
   logic                  tx_push_s;
   logic                  tx_pop_s;
   logic                  tx_full_next_s;

   stall_state_t          stall_state_r;
   logic [15:0]           burst_cnt_r;
   logic [15:0]           gap_cnt_r;
   logic                  err_s;

   assign rx_head_s     = rx_mem_r[rx_rd_ptr_r];
   assign ft_data       = ft_oe_n ? 8'bzzzz_zzzz : rx_head_s;
   assign host_rx_ready = ~rst & (rx_count != FULL_CNT);
   assign rx_push_s     = host_rx_valid & host_rx_ready;
   // RXF# is low only while the FIFO holds data, so this never pops an empty FIFO.
   assign rx_pop_s      = ~ft_rd_n & ~ft_oe_n & ~ft_rxf_n;

   assign host_tx_valid = ~rst & (tx_count != ZERO_CNT);
   assign host_tx_data  = tx_mem_r[tx_rd_ptr_r];
   assign tx_pop_s      = host_tx_valid & host_tx_ready;
   assign tx_push_s     = ~rst & ~ft_wr_n & ~ft_txe_n & ft_oe_n;
   assign err_s         = ~ft_wr_n & (~ft_oe_n | ft_txe_n);

   // Next-state occupancy of both FIFOs.
   always_comb begin
      rx_count_next_s = rx_count;
      tx_count_next_s = tx_count;
      if (rx_push_s && !rx_pop_s) begin
         rx_count_next_s = rx_count + ONE_CNT;
      end else if (!rx_push_s && rx_pop_s) begin
         rx_count_next_s = rx_count - ONE_CNT;
      end else begin
         rx_count_next_s = rx_count;
      end
      if (tx_push_s && !tx_pop_s) begin
         tx_count_next_s = tx_count + ONE_CNT;
      end else if (!tx_push_s && tx_pop_s) begin
         tx_count_next_s = tx_count - ONE_CNT;
      end else begin
         tx_count_next_s = tx_count;
      end
      tx_full_next_s = (tx_count_next_s == FULL_CNT);
   end

   // FIFO storage; contents need no reset because pointers define validity.
   always_ff @(posedge ft_clk) begin
      if (rx_push_s) begin
         rx_mem_r[rx_wr_ptr_r] <= host_rx_data;
      end
      if (tx_push_s) begin
         tx_mem_r[tx_wr_ptr_r] <= ft_data;
      end
   end

   // RX FIFO pointers, occupancy and RXF#.
   always_ff @(posedge ft_clk) begin
      if (rst) begin
         rx_wr_ptr_r <= '0;
         rx_rd_ptr_r <= '0;
         rx_count    <= ZERO_CNT;
         ft_rxf_n    <= 1'b1;
      end else begin
         if (rx_push_s) begin
            rx_wr_ptr_r <= rx_wr_ptr_r + ONE_PTR;
         end
         if (rx_pop_s) begin
            rx_rd_ptr_r <= rx_rd_ptr_r + ONE_PTR;
         end
         rx_count <= rx_count_next_s;
         ft_rxf_n <= (rx_count_next_s == ZERO_CNT);
      end
   end

   // TX FIFO pointers and occupancy.
   always_ff @(posedge ft_clk) begin
      if (rst) begin
         tx_wr_ptr_r <= '0;
         tx_rd_ptr_r <= '0;
         tx_count    <= ZERO_CNT;
      end else begin
         if (tx_push_s) begin
            tx_wr_ptr_r <= tx_wr_ptr_r + ONE_PTR;
         end
         if (tx_pop_s) begin
            tx_rd_ptr_r <= tx_rd_ptr_r + ONE_PTR;
         end
         tx_count <= tx_count_next_s;
      end
   end

   // Stall FSM and TXE#: full and stall are ORed; the gap timer runs regardless of fill.
   always_ff @(posedge ft_clk) begin
      if (rst) begin
         stall_state_r <= ST_OPEN;
         burst_cnt_r   <= 16'd0;
         gap_cnt_r     <= 16'd0;
         ft_txe_n      <= 1'b1;
      end else begin
         case (stall_state_r)
            ST_OPEN: begin
               if (STALL_EN && tx_push_s && (burst_cnt_r == BURST_LAST)) begin
                  stall_state_r <= ST_GAP;
                  burst_cnt_r   <= 16'd0;
                  gap_cnt_r     <= GAP_LAST;
                  ft_txe_n      <= 1'b1;
               end else begin
                  if (STALL_EN && tx_push_s) begin
                     burst_cnt_r <= burst_cnt_r + 16'd1;
                  end
                  ft_txe_n <= tx_full_next_s;
               end
            end
            ST_GAP: begin
               if (gap_cnt_r == 16'd0) begin
                  stall_state_r <= ST_OPEN;
                  ft_txe_n      <= tx_full_next_s;
               end else begin
                  gap_cnt_r <= gap_cnt_r - 16'd1;
                  ft_txe_n  <= 1'b1;
               end
            end
            default: begin
               stall_state_r <= ST_OPEN;
               burst_cnt_r   <= 16'd0;
               gap_cnt_r     <= 16'd0;
               ft_txe_n      <= 1'b1;
            end
         endcase
      end
   end

   // Sticky protocol-violation flag.
   always_ff @(posedge ft_clk) begin
      if (rst) begin
         proto_err <= 1'b0;
      end else if (err_s) begin
         proto_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ft245_sync_fifo_device.sv
// Self-checking bench for ft245_sync_fifo_device (DEPTH=16, TX_BURST=4, TX_GAP=3).
module tb_ft245_sync_fifo_device;

   logic       ft_clk = 1'b0;
   logic       rst;
   logic       ft_rxf_n, ft_txe_n;
   logic       ft_oe_n, ft_rd_n, ft_wr_n;
   wire  [7:0] ft_data;
   logic [7:0] host_rx_data;
   logic       host_rx_valid, host_rx_ready;
   logic [7:0] host_tx_data;
   logic       host_tx_valid, host_tx_ready;
   logic [4:0] rx_count, tx_count;
   logic       proto_err;

   logic [7:0] drv_data;
   logic       drv_en;
   assign ft_data = drv_en ? drv_data : 8'bzzzz_zzzz;

   ft245_sync_fifo_device #(
      .DEPTH_LOG2 (4),
      .TX_BURST   (4),
      .TX_GAP     (3)
   ) dut (
      .ft_clk        (ft_clk),
      .rst           (rst),
      .ft_rxf_n      (ft_rxf_n),
      .ft_txe_n      (ft_txe_n),
      .ft_oe_n       (ft_oe_n),
      .ft_rd_n       (ft_rd_n),
      .ft_wr_n       (ft_wr_n),
      .ft_data       (ft_data),
      .host_rx_data  (host_rx_data),
      .host_rx_valid (host_rx_valid),
      .host_rx_ready (host_rx_ready),
      .host_tx_data  (host_tx_data),
      .host_tx_valid (host_tx_valid),
      .host_tx_ready (host_tx_ready),
      .rx_count      (rx_count),
      .tx_count      (tx_count),
      .proto_err     (proto_err)
   );

   always #5 ft_clk = ~ft_clk;

   int total = 0;
   int bad   = 0;
   logic [7:0] rx_q[$];
   logic [7:0] tx_q[$];

   // TX-side reference model of occupancy and stall
   int   n_wr = 0;
   int   gap_left = 0;
   int   mcount = 0;
   int   sent = 0;
   int   tx_limit = 0;
   logic [7:0] tx_base = 8'h00;

   typedef struct {
      logic       push;
      logic [7:0] din;
      logic       pop;
      logic       exp_rxf_n;
      logic [4:0] exp_cnt;
   } rx_vec_t;
   rx_vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge ft_clk);
      #1;
   endtask

   // One master cycle: write when the model says TXE# is low and bytes remain.
   task automatic tx_cycle();
      logic exp_txe;
      logic do_wr;
      exp_txe = (gap_left > 0) || (mcount == 16);
      check("tx_txe_n", 32'(ft_txe_n), 32'(exp_txe));
      do_wr = !exp_txe && (sent < tx_limit);
      if (do_wr) begin
         ft_wr_n  = 1'b0;
         drv_en   = 1'b1;
         drv_data = tx_base + 8'(sent);
         tx_q.push_back(tx_base + 8'(sent));
         sent++;
      end else begin
         ft_wr_n = 1'b1;
         drv_en  = 1'b0;
      end
      step();
      if (do_wr) begin
         n_wr++;
         mcount++;
         if (n_wr % 4 == 0) gap_left = 3;
      end else if (gap_left > 0) begin
         gap_left--;
      end
      check("tx_count", 32'(tx_count), 32'(mcount));
   endtask

   initial begin
      vecs[0] = '{1'b1, 8'hA1, 1'b0, 1'b0, 5'd1};
      vecs[1] = '{1'b1, 8'hA2, 1'b1, 1'b0, 5'd1};
      vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1};
      vecs[3] = '{1'b1, 8'hA3, 1'b1, 1'b0, 5'd1};
      vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 5'd0};
      vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 5'd0};

      rst = 1'b1; ft_oe_n = 1'b1; ft_rd_n = 1'b1; ft_wr_n = 1'b1;
      host_rx_valid = 1'b1; host_rx_data = 8'hEE; host_tx_ready = 1'b0;
      drv_en = 1'b0; drv_data = 8'h00;

      // reset
      repeat (3) step();
      check("rst_rxf_n", 32'(ft_rxf_n), 32'd1);
      check("rst_txe_n", 32'(ft_txe_n), 32'd1);
      check("rst_rx_count", 32'(rx_count), 32'd0);
      check("rst_tx_count", 32'(tx_count), 32'd0);
      check("rst_proto_err", 32'(proto_err), 32'd0);
      check("rst_rx_ready", 32'(host_rx_ready), 32'd0);
      check("rst_tx_valid", 32'(host_tx_valid), 32'd0);
      drv_en = 1'b1; drv_data = 8'h3C; #1;
      check("rst_bus_released", 32'(ft_data), 32'h3C);
      drv_en = 1'b0;
      rst = 1'b0; host_rx_valid = 1'b0;
      step();
      check("post_rst_txe_n", 32'(ft_txe_n), 32'd0);
      check("post_rst_rxf_n", 32'(ft_rxf_n), 32'd1);
      check("post_rst_rx_count", 32'(rx_count), 32'd0);

      // RX ordering
      for (int i = 0; i < 3; i++) begin
         host_rx_valid = 1'b1;
         host_rx_data  = 8'h11 * 8'(i + 1);
         rx_q.push_back(8'h11 * 8'(i + 1));
         step();
         if (i == 0) begin
            check("rx_first_rxf_n", 32'(ft_rxf_n), 32'd0);
            check("rx_first_count", 32'(rx_count), 32'd1);
         end
      end
      host_rx_valid = 1'b0;
      check("rx_count3", 32'(rx_count), 32'd3);
      drv_en = 1'b1; drv_data = 8'h00; #1;
      check("rx_bus_released", 32'(ft_data), 32'h00);
      drv_en = 1'b0;
      ft_oe_n = 1'b0;
      step();
      ft_rd_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("rx_order_data", 32'(ft_data), 32'(rx_q.pop_front()));
         step();
         check("rx_order_rxf_n", 32'(ft_rxf_n), (i == 2) ? 32'd1 : 32'd0);
         check("rx_order_count", 32'(rx_count), 32'(2 - i));
      end
      step();
      check("rd_empty_count", 32'(rx_count), 32'd0);
      check("rd_empty_proto_err", 32'(proto_err), 32'd0);
      ft_rd_n = 1'b1; ft_oe_n = 1'b1;

      // RX boundary vectors
      for (int i = 0; i < 6; i++) begin
         host_rx_valid = vecs[i].push;
         host_rx_data  = vecs[i].din;
         ft_oe_n       = ~vecs[i].pop;
         ft_rd_n       = ~vecs[i].pop;
         #1;
         if (vecs[i].pop && rx_q.size() > 0) begin
            check("vec_data", 32'(ft_data), 32'(rx_q.pop_front()));
         end
         if (vecs[i].push) rx_q.push_back(vecs[i].din);
         step();
         check("vec_rxf_n", 32'(ft_rxf_n), 32'(vecs[i].exp_rxf_n));
         check("vec_count", 32'(rx_count), 32'(vecs[i].exp_cnt));
      end
      host_rx_valid = 1'b0; ft_oe_n = 1'b1; ft_rd_n = 1'b1;

      // RX full then drain
      for (int i = 0; i < 16; i++) begin
         host_rx_valid = 1'b1;
         host_rx_data  = 8'hC0 + 8'(i);
         rx_q.push_back(8'hC0 + 8'(i));
         step();
      end
      host_rx_data = 8'hFF; #1;
      check("rx_full_ready", 32'(host_rx_ready), 32'd0);
      check("rx_full_count", 32'(rx_count), 32'd16);
      step();
      check("rx_full_hold", 32'(rx_count), 32'd16);
      host_rx_valid = 1'b0;
      ft_oe_n = 1'b0; ft_rd_n = 1'b0;
      for (int i = 0; i < 16; i++) begin
         #1;
         check("rx_drain_data", 32'(ft_data), 32'(rx_q.pop_front()));
         step();
      end
      ft_oe_n = 1'b1; ft_rd_n = 1'b1;
      check("rx_drain_rxf_n", 32'(ft_rxf_n), 32'd1);
      check("rx_drain_count", 32'(rx_count), 32'd0);

      // TX stall bursts
      sent = 0; tx_limit = 10; tx_base = 8'h00;
      for (int c = 0; c < 30; c++) tx_cycle();
      ft_wr_n = 1'b1; drv_en = 1'b0;
      host_tx_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         check("tx_drain_valid", 32'(host_tx_valid), 32'd1);
         check("tx_drain_data", 32'(host_tx_data), 32'(tx_q.pop_front()));
         step();
         mcount--;
      end
      host_tx_ready = 1'b0;
      check("tx_empty_count", 32'(tx_count), 32'd0);
      check("tx_empty_valid", 32'(host_tx_valid), 32'd0);
      check("tx_empty_txe_n", 32'(ft_txe_n), 32'd0);

      // TX full
      sent = 0; tx_limit = 20; tx_base = 8'h40;
      for (int c = 0; c < 60; c++) tx_cycle();
      ft_wr_n = 1'b1; drv_en = 1'b0;
      check("tx_full_txe_n", 32'(ft_txe_n), 32'd1);
      check("tx_full_count", 32'(tx_count), 32'd16);
      check("tx_full_proto_err", 32'(proto_err), 32'd0);
      check("tx_full_head", 32'(host_tx_data), 32'h40);
      ft_wr_n = 1'b0; drv_en = 1'b1; drv_data = 8'h99;
      step();
      ft_wr_n = 1'b1; drv_en = 1'b0;
      check("err_txe_flag", 32'(proto_err), 32'd1);
      check("err_txe_count", 32'(tx_count), 32'd16);
      check("err_txe_head", 32'(host_tx_data), 32'h40);

      // reset in the middle of traffic
      host_rx_valid = 1'b1; host_rx_data = 8'h5A;
      repeat (2) step();
      host_rx_valid = 1'b0;
      check("mid_rx_count", 32'(rx_count), 32'd2);
      rst = 1'b1;
      step();
      check("mid_rst_rx_count", 32'(rx_count), 32'd0);
      check("mid_rst_tx_count", 32'(tx_count), 32'd0);
      check("mid_rst_proto_err", 32'(proto_err), 32'd0);
      check("mid_rst_rxf_n", 32'(ft_rxf_n), 32'd1);
      check("mid_rst_tx_valid", 32'(host_tx_valid), 32'd0);
      rst = 1'b0;
      rx_q.delete(); tx_q.delete();
      n_wr = 0; gap_left = 0; mcount = 0;
      step();
      check("mid_post_txe_n", 32'(ft_txe_n), 32'd0);

      // bus contention error
      ft_oe_n = 1'b0; ft_wr_n = 1'b0;
      step();
      ft_oe_n = 1'b1; ft_wr_n = 1'b1;
      check("err_oe_flag", 32'(proto_err), 32'd1);
      check("err_oe_tx_count", 32'(tx_count), 32'd0);
      repeat (3) step();
      check("err_sticky", 32'(proto_err), 32'd1);
      ft_wr_n = 1'b0; drv_en = 1'b1; drv_data = 8'h77;
      step();
      ft_wr_n = 1'b1; drv_en = 1'b0;
      check("post_err_count", 32'(tx_count), 32'd1);
      check("post_err_head", 32'(host_tx_data), 32'h77);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
